popcount_sequencer: RTL and testbench
=====================================

# popcount_sequencer

Multi-cycle population counter for words wider than one byte. It accepts an `8*NBYTES`-bit word over a valid/ready handshake. It then steps the word byte by byte through a single shared `count_ones` instance (8-bit `binary_number` in, 4-bit `num_of_ones` out) and accumulates the partial counts. The total is returned over a second valid/ready handshake, so wide-word popcount costs no more combinational logic than the existing byte counter.

## Interface
- `NBYTES`, default 4: number of bytes per input word, ≥1.
- `CW`, derived as `$clog2(8*NBYTES+1)` (6 for the default): result width; not overridable.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: block can accept a word; equals `(state==IDLE) && rst_n`.
- `in_data`  in  `8*NBYTES`: word to count; sampled only on the accept edge.
- `out_valid`  out  1: `out_count` is valid (registered).
- `out_ready`  in  1: consumer takes the result.
- `out_count`  out  `CW`: number of 1 bits in the accepted word (registered).
- `busy`  out  1: high when `state != IDLE`.

## Operation
- Registers:
  - `shreg`, `8*NBYTES` bits: remaining data.
  - `acc`, `CW` bits: running total.
  - `idx`, `$clog2(NBYTES)` bits (minimum 1 bit): byte index.
  - `state`: one of IDLE, RUN, DONE.
- `count_ones.binary_number` is driven by `shreg[7:0]` and is the only popcount logic in the block.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid && in_ready`: `shreg<=in_data`, `acc<=0`, `idx<=0`, go to RUN.
- **RUN** (one byte per cycle)
  - `sum = acc + num_of_ones` (zero-extended to `CW`).
  - `shreg <= shreg >> 8`, `idx <= idx+1`.
  - Last byte: when `idx==NBYTES-1`, `out_count<=sum`, `out_valid<=1`, go to DONE.
  - Otherwise `acc<=sum`, stay in RUN.
- **DONE**
  - `out_valid` and `out_count` are held stable.
  - On `out_ready`: `out_valid<=0`, go to IDLE.
  - `out_count` keeps its last value after the handshake.
- `in_ready=0` in RUN and DONE. There is no overlap between words.
- Arithmetic: `acc` never overflows; its maximum is `8*NBYTES` and fits in `CW`.
- Reset values: state=IDLE, `out_valid=0`, `out_count=0`, `acc=0`, `shreg=0`, `idx=0`, `busy=0`. `in_ready=0` while `rst_n` is low.
- Reset mid-operation (RUN or DONE): the word or result is discarded, no `out_valid` pulse is produced, and the block is in IDLE on the next cycle.
- Simultaneous `rst_n=0` with `in_valid` or `out_ready`: reset wins and no handshake completes.
- `in_valid` held while `busy`: ignored. The word is accepted on the first IDLE cycle it is still presented.

## Timing
- The accept edge is E0.
- `out_valid` rises after edge E0+NBYTES; latency is NBYTES cycles.
- With `out_ready` held high, `out_valid` is high for exactly 1 cycle. `in_ready` returns the cycle after the result handshake.
- Minimum initiation interval: NBYTES+2 cycles.
- Outputs depend combinationally only on `state` and `rst_n` (`in_ready`, `busy`). There is no input-to-output combinational path.

## Configuration
- Macro: `POPCOUNT_SEQ_EARLY_EXIT_EN`.
- When defined, the RUN exit condition becomes `idx==NBYTES-1` OR `(shreg>>8)==0`. The block goes to DONE on the first edge after which no set bits remain.
  - Latency becomes 1 + index of the highest nonzero byte (1 for an all-zero word).
  - `out_count` is unchanged.
- When undefined, latency is always NBYTES; the shift-register zero detector is not synthesized.

## Test plan
- **Reset:** hold `rst_n=0` for 3 cycles with `in_valid=1` and `in_data=32'hFFFFFFFF` → `in_ready=0`, `out_valid=0`, `out_count=0`, `busy=0` throughout. `in_ready=1` on the first cycle after release.
- **Full word:** NBYTES=4, `in_data=32'hFFFFFFFF`, `out_ready=1` → `out_valid` is high 4 cycles after accept for 1 cycle with `out_count=32`. `in_ready` is 0 for the 5 cycles after accept.
- **Back-to-back with back-pressure:**
  - Words `32'h00000001`, `32'h55555555`, `32'hD573FF07` → counts 1, 16, 21.
  - On the third word, hold `out_ready=0` for 5 cycles → `out_valid=1` and `out_count=21` are stable, `in_ready=0`.
- **Reset mid-RUN:** accept `32'hFFFFFFFF`, pull `rst_n` low after 2 RUN cycles → no `out_valid`. Next word `32'h0000000F` → `out_count=4` after 4 cycles.
- **Early exit:**
  - With `POPCOUNT_SEQ_EARLY_EXIT_EN`: `32'h00000000` → count 0 after 1 cycle; `32'h00FF0000` → count 8 after 3 cycles.
  - Without the macro: both words take 4 cycles, with the same counts.
- **Parameter sweep:**
  - NBYTES=1: `8'hA5` → `out_count=4` after 1 cycle, `CW=4`.
  - NBYTES=3: `24'hFFFFFF` → `out_count=24` after 3 cycles, `CW=5`.

Source files
------------

// File: rtl/popcount_sequencer_if.sv
// Handshake bundle for popcount_sequencer: word in, count out, busy status.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready follow the usual valid/ready rules.
//
// Ports (signals):
//   in_valid/in_ready/in_data    : word offered by the producer
//   out_valid/out_ready/out_count: result offered to the consumer
//   busy                         : block is working on or holding a word
// master = producer/consumer side, slave = popcount_sequencer side.
interface popcount_sequencer_if #(
  parameter int NBYTES = 4
);
  localparam int CW = $clog2(8 * NBYTES + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CW-1:0]         out_count;
  logic                  busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count, busy
  );
endinterface

// File: rtl/popcount_sequencer.sv
// Multi-cycle popcount of an 8*NBYTES-bit word through one shared byte counter.
// Latency: NBYTES cycles accept-to-out_valid (early exit: 1 + highest nonzero byte index).
// Backpressure: one word in flight; in_ready low until the result is taken via out_ready.
//
// Ports: clk, rst_n (synchronous, active-low), bus (popcount_sequencer_if.slave).
// Optional feature macro: POPCOUNT_SEQ_EARLY_EXIT_EN -- finish as soon as no
// set bits remain in the shift register.

// Byte popcount: 8-bit binary_number in, 4-bit num_of_ones out.
// Latency: combinational.
// Backpressure: none.
module count_ones (
  input  logic [7:0] binary_number,
  output logic [3:0] num_of_ones
);
  always_comb begin
    num_of_ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      num_of_ones = num_of_ones + {3'b000, binary_number[i]};
    end
  end
endmodule

module popcount_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  popcount_sequencer_if.slave  bus
);
  localparam int CW = $clog2(8 * NBYTES + 1);
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int W  = 8 * NBYTES;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    shreg;
  logic [W-1:0]    shreg_rest;
  logic [CW-1:0]   acc;
  logic [CW-1:0]   sum;
  logic [IW-1:0]   idx;
  logic [3:0]      byte_ones;
  logic            last_byte;
  logic            run_exit_cond;
  logic            accept;
  logic            run_exit;
  logic            out_valid_q;
  logic [CW-1:0]   out_count_q;

  // The only popcount logic in the block: always looks at the low byte.
  count_ones u_count_ones (
    .binary_number (shreg[7:0]),
    .num_of_ones   (byte_ones)
  );

  assign shreg_rest = shreg >> 8;
  assign sum        = acc + CW'(byte_ones);
  assign last_byte  = (idx == IW'(NBYTES - 1));

`ifdef POPCOUNT_SEQ_EARLY_EXIT_EN
  // Nothing left above the current byte means the current sum is final.
  assign run_exit_cond = last_byte || (shreg_rest == '0);
`else
  assign run_exit_cond = last_byte;
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    run_exit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        run_exit = run_exit_cond;
        if (run_exit_cond) state_nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      acc         <= '0;
      idx         <= '0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        shreg <= bus.in_data;
        acc   <= '0;
        idx   <= '0;
      end
      if (state == RUN) begin
        shreg <= shreg_rest;
        idx   <= idx + IW'(1);
        if (run_exit) begin
          out_count_q <= sum;
          out_valid_q <= 1'b1;
        end else begin
          acc <= sum;
        end
      end
      if (state == DONE && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE) && rst_n;
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_count = out_count_q;
endmodule

// File: tb/tb_popcount_sequencer.sv
// Self-checking bench for popcount_sequencer: directed scenarios plus random traffic.
// Latency: n/a.
// Backpressure: random and directed out_ready stalls.
module tb_popcount_sequencer;
  localparam int NB = 4;
  localparam int W  = 8 * NB;
`ifdef POPCOUNT_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk;
  logic rst_n;

  popcount_sequencer_if #(.NBYTES(NB)) bus  ();
  popcount_sequencer_if #(.NBYTES(1))  bus1 ();
  popcount_sequencer_if #(.NBYTES(3))  bus3 ();

  popcount_sequencer #(.NBYTES(NB)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  popcount_sequencer #(.NBYTES(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  popcount_sequencer #(.NBYTES(3))  dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference rules: number of ones, and cycles from accept to out_valid.
  function automatic int ref_pop(input logic [W-1:0] d);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(d[i]);
    return n;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] d);
    if (!EARLY) return NB;
    for (int k = NB - 1; k >= 0; k--) if (d[8*k +: 8] != 8'h00) return k + 1;
    return 1;
  endfunction

  // Behavioural model: idle, or waiting out a known latency, or holding a result.
  bit m_idle      = 1'b1;
  int m_wait      = 0;
  int m_pending   = 0;
  bit m_out_valid = 1'b0;
  int m_out_count = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_idle = 1'b1; m_wait = 0; m_out_valid = 1'b0; m_out_count = 0;
    end else if (m_idle) begin
      if (bus.in_valid) begin
        m_idle    = 1'b0;
        m_wait    = ref_lat(bus.in_data);
        m_pending = ref_pop(bus.in_data);
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_out_valid = 1'b1;
        m_out_count = m_pending;
      end
    end else if (bus.out_ready) begin
      m_out_valid = 1'b0;
      m_idle      = 1'b1;
    end
    #1;
    check("in_ready",  bus.in_ready,  longint'(m_idle && rst_n));
    check("busy",      bus.busy,      longint'(!m_idle));
    check("out_valid", bus.out_valid, longint'(m_out_valid));
    check("out_count", bus.out_count, m_out_count);
  end

  task automatic run_word(input logic [W-1:0] d, input int exp_cnt, input int exp_lat,
                          input int hold, input string tag);
    int k;
    int lat;
    @(negedge clk);
    k = 0;
    while (!bus.in_ready && k < 50) begin @(negedge clk); k++; end
    check({tag, "_ready_wait"}, longint'(bus.in_ready), 1);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.out_ready = (hold == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin @(negedge clk); lat++; end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_count"},   bus.out_count, exp_cnt);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, bus.out_valid, 1);
      check({tag, "_hold_count"}, bus.out_count, exp_cnt);
      check({tag, "_hold_inrdy"}, bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid_drop"}, bus.out_valid, 0);
    check({tag, "_ready_back"}, bus.in_ready, 1);
    check({tag, "_count_kept"}, bus.out_count, exp_cnt);
  endtask

  initial begin
    logic [W-1:0] d;
    int k;
    bus.in_valid = 1'b0;  bus.in_data = '0;  bus.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.out_ready = 1'b0;

    // Pin the reference functions with hand-computed values.
    check("ref_pop_d573ff07", ref_pop(32'hD573FF07), 21);
    check("ref_pop_55555555", ref_pop(32'h55555555), 16);
    check("ref_lat_00ff0000", ref_lat(32'h00FF0000), EARLY ? 3 : 4);
    check("ref_lat_zero",     ref_lat(32'h00000000), EARLY ? 1 : 4);

    // Reset held with a word offered.
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_in_ready",  bus.in_ready,  0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_count", bus.out_count, 0);
      check("rst_busy",      bus.busy,      0);
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("rel_in_ready", bus.in_ready, 1);

    run_word(32'hFFFFFFFF, 32, 4, 0, "full");
    run_word(32'h00000001, 1, 4, 0, "b2b1");
    run_word(32'h55555555, 16, 4, 0, "b2b2");
    run_word(32'hD573FF07, 21, 4, 5, "b2b3");

    // Reset two RUN cycles into a word.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 32'hFFFFFFFF; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", bus.busy, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_valid", bus.out_valid, 0);
    end
    run_word(32'h0000000F, 4, 4, 0, "post_rst");

    run_word(32'h00000000, 0, EARLY ? 1 : 4, 0, "early_zero");
    run_word(32'h00FF0000, 8, EARLY ? 3 : 4, 0, "early_b2");

    // Narrow and odd widths.
    check("cw_nb1", dut1.CW, 4);
    check("cw_nb3", dut3.CW, 5);
    @(negedge clk);
    check("nb1_ready", bus1.in_ready, 1);
    bus1.in_valid = 1'b1; bus1.in_data = 8'hA5; bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    k = 0;
    while (!bus1.out_valid && k < 20) begin @(negedge clk); k++; end
    check("nb1_latency", k, 1);
    check("nb1_count", bus1.out_count, 4);
    @(negedge clk);
    check("nb1_drop", bus1.out_valid, 0);

    check("nb3_ready", bus3.in_ready, 1);
    bus3.in_valid = 1'b1; bus3.in_data = 24'hFFFFFF; bus3.out_ready = 1'b1;
    @(negedge clk);
    bus3.in_valid = 1'b0;
    k = 0;
    while (!bus3.out_valid && k < 20) begin @(negedge clk); k++; end
    check("nb3_latency", k, 3);
    check("nb3_count", bus3.out_count, 24);
    @(negedge clk);
    check("nb3_drop", bus3.out_valid, 0);

    // Random traffic, stalls and occasional resets against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      d = W'($urandom);
      for (int b = 0; b < NB; b++) if ($urandom_range(0, 2) == 0) d[8*b +: 8] = 8'h00;
      if ($urandom_range(0, 9) == 0) d = '1;
      rst_n         = ($urandom_range(0, 149) != 0);
      bus.in_valid  = ($urandom_range(0, 1) == 1);
      bus.in_data   = d;
      bus.out_ready = ($urandom_range(0, 9) < 7);
    end
    @(negedge clk);
    rst_n = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (NB + 4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
